audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
- Downstream consumer of the synthesizer's 16-bit mixed output.
- Accepts stereo sample pairs over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each pair onto an I2S bus (sclk, lrclk, sdata) to drive an external DAC.
- Generates all bus clocks from the single system clock; flags FIFO underruns.

Parameters:
- SAMPLE_W, 16, bits per channel word; legal range 8..32.
- FIFO_DEPTH, 4, stereo pairs buffered; power of two, at least 2.
- SCLK_DIV, 4, clk cycles per sclk half-period; at least 1.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  upstream pair is valid.
- sample_ready  out  1  FIFO can accept a pair.
- sample_left  in  SAMPLE_W  left word, two's complement.
- sample_right  in  SAMPLE_W  right word, two's complement.
- sclk  out  1  I2S bit clock.
- lrclk  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous deassert on clk):
  - sclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, sample_ready=1.
  - Divider=0, bit_cnt=2*SAMPLE_W-1, shift register all zeros, FIFO emptied.
- Handshake:
  - A pair is pushed on the clk edge where sample_valid && sample_ready.
  - sample_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
  - Data is sampled only on the push edge; the port may change freely otherwise.
- Clock divider:
  - Counter runs 0..SCLK_DIV-1; sclk toggles when it wraps.
  - sclk period is 2*SCLK_DIV clk cycles.
  - A "fall event" is the clk cycle on which sclk goes 1 to 0.
- Each fall event:
  - bit_cnt advances mod 2*SAMPLE_W.
  - lrclk and sdata update in the same cycle as sclk falls; the DAC samples on sclk rise.
- lrclk = 0 while the new bit_cnt < SAMPLE_W, otherwise 1.
- Frame layout (default, I2S one-bit delay):
  - Frame vector F = {left, right}, 2*SAMPLE_W bits, MSB first.
  - At bit_cnt=k, sdata = F bit (k-1) mod 2*SAMPLE_W of the current frame.
  - Consequence: at bit_cnt=0, sdata is the previous frame's right LSB.
- Load:
  - On the fall event that makes bit_cnt=1, the FIFO head is popped into the shift register before sdata is driven.
  - That cycle emits the left MSB.
  - If the FIFO is empty at that point: load all zeros, assert underrun for exactly that one clk, leave fifo_level unchanged.
- Simultaneous push and pop in one cycle: level unchanged, both take effect.
  - Push is permitted when full only if a pop occurs in that same cycle? No: sample_ready depends on the registered level only, so a full FIFO rejects the push.
- FIFO pointers wrap mod FIFO_DEPTH; fifo_level is the true count 0..FIFO_DEPTH.
- Reset asserted mid-frame: all outputs return to reset values immediately and buffered pairs are discarded.
- Per-frame cost: 2*SAMPLE_W*2*SCLK_DIV clk cycles; 256 at the defaults.

Optional Feature:
- Macro: AUDIO_I2S_TX_LEFT_JUSTIFY_EN.
- Defined:
  - Left-justified format with no one-bit delay: at bit_cnt=k, sdata = F bit k.
  - Pop and load occur on the fall event that makes bit_cnt=0.
  - lrclk timing is unchanged.
  - The underrun check moves to the same point.
- Undefined: standard I2S timing as in Behaviour.

Test Plan:
- Reset release, no pushes:
  - sclk first rises 4 clks after reset deassert and has period 8 clks.
  - lrclk stays 0 for 16 sclk periods, then 1 for 16.
  - sdata stays 0.
  - underrun pulses once per 256 clks.
- Push L=16'hA5F0, R=16'h0001, then idle:
  - Captured on sclk rises, the frame is: bit0 = 0 (prior right LSB), bits 1..16 = A5F0 MSB first.
  - Bits 17..31 = 15 bits of 0001 MSB first, so the last bit is 0.
  - The next frame's bit0 is 1; the next frame underruns.
- Push 4 pairs back-to-back with no frame boundary:
  - fifo_level reaches 4 and sample_ready drops to 0.
  - A 5th push held valid is accepted only after the next load pops.
  - Pairs emerge in order with no underrun.
- Push coincident with pop at fifo_level=2: level stays 2 and data order is preserved.
- Assert reset_n low mid-right-word with 3 pairs queued:
  - Outputs go to reset values asynchronously.
  - After release, fifo_level=0 and the first frame underruns.
- With AUDIO_I2S_TX_LEFT_JUSTIFY_EN, push L=16'h8000, R=16'h7FFF:
  - bit0=1, bits 1..15=0, bit16=0, bits 17..31=1.
  - lrclk edges align with bit0 and bit16.

Source files
------------

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Brief    : Stereo sample FIFO and I2S serializer with clk-derived sclk/lrclk
//            and underrun flag. Define AUDIO_I2S_TX_LEFT_JUSTIFY_EN to select
//            left-justified framing instead of standard I2S.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [SAMPLE_W-1:0]           sample_left,
    input  logic [SAMPLE_W-1:0]           sample_right,
    output logic                          sclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_frame_w = 2 * SAMPLE_W;
    localparam int c_cnt_w   = $clog2(c_frame_w);
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w   = c_ptr_w + 1;
    localparam int c_div_w   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_frame_w - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_word = c_cnt_w'(SAMPLE_W);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCLK_DIV - 1);
    localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(FIFO_DEPTH);
`ifdef AUDIO_I2S_TX_LEFT_JUSTIFY_EN
    localparam logic [c_cnt_w-1:0] c_load_cnt = '0;
`else
    // Loading one slot late yields the I2S one-bit delay behind lrclk.
    localparam logic [c_cnt_w-1:0] c_load_cnt = c_cnt_w'(1);
`endif

    logic [c_div_w-1:0]   div_q, div_d;
    logic                 sclk_q, sclk_d;
    logic [c_cnt_w-1:0]   bit_cnt_q, bit_cnt_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 underrun_q, underrun_d;
    logic [c_frame_w-1:0] shift_q, shift_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0]   level_q, level_d;
    logic [c_frame_w-1:0] mem_q [FIFO_DEPTH];
    logic [c_frame_w-1:0] mem_d [FIFO_DEPTH];

    logic                 w_wrap;
    logic                 w_fall;
    logic                 w_push;
    logic                 w_pop;
    logic [c_frame_w-1:0] w_head;

    assign sample_ready = (level_q != c_lvl_full);
    assign w_head       = mem_q[rd_ptr_q];
    assign w_wrap       = (div_q == c_div_last);
    assign w_fall       = w_wrap && sclk_q;
    assign w_push       = sample_valid && sample_ready;

    always_comb begin
        div_d      = w_wrap ? '0 : div_q + 1'b1;
        sclk_d     = w_wrap ? ~sclk_q : sclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        mem_d      = mem_q;
        w_pop      = 1'b0;

        if (w_fall) begin
            bit_cnt_d = (bit_cnt_q == c_cnt_last) ? '0 : bit_cnt_q + 1'b1;
            lrclk_d   = (bit_cnt_d >= c_cnt_word);
            if (bit_cnt_d == c_load_cnt) begin
                // Empty FIFO at a frame start plays silence rather than stale data.
                if (level_q != '0) begin
                    w_pop    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    sdata_d  = w_head[c_frame_w-1];
                    shift_d  = {w_head[c_frame_w-2:0], 1'b0};
                end else begin
                    underrun_d = 1'b1;
                    sdata_d    = 1'b0;
                    shift_d    = '0;
                end
            end else begin
                sdata_d = shift_q[c_frame_w-1];
                shift_d = {shift_q[c_frame_w-2:0], 1'b0};
            end
        end

        if (w_push) begin
            mem_d[wr_ptr_q] = {sample_left, sample_right};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            sclk_q     <= 1'b0;
            bit_cnt_q  <= c_cnt_last;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign sclk       = sclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_tx
// Brief    : Randomized bench for audio_i2s_tx against a frame-level model
//            driven by clk-cycle arithmetic and a queue of stereo pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

    localparam int c_w     = 16;
    localparam int c_fw    = 2 * c_w;
    localparam int c_depth = 4;
    localparam int c_div   = 4;
`ifdef AUDIO_I2S_TX_LEFT_JUSTIFY_EN
    localparam int c_load_k = 0;
    localparam int c_ofs    = 0;
`else
    localparam int c_load_k = 1;
    localparam int c_ofs    = 1;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           sample_valid = 1'b0;
    logic           sample_ready;
    logic [c_w-1:0] sample_left = '0;
    logic [c_w-1:0] sample_right = '0;
    logic           sclk, lrclk, sdata, underrun;
    logic [2:0]     fifo_level;

    audio_i2s_tx #(
        .SAMPLE_W   (c_w),
        .FIFO_DEPTH (c_depth),
        .SCLK_DIV   (c_div)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: clk edges since reset release, queued frames, current frame.
    int              cyc;
    logic [c_fw-1:0] m_q[$];
    logic [c_fw-1:0] m_frame;
    logic            m_sclk, m_lrclk, m_sdata, m_underrun;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", tag, $time, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        m_q.delete();
        m_frame    = '0;
        m_sclk     = 1'b0;
        m_lrclk    = 1'b0;
        m_sdata    = 1'b0;
        m_underrun = 1'b0;
    endtask

    task automatic model_step();
        int  n, k, idx;
        logic push_now;
        cyc++;
        push_now   = sample_valid && (m_q.size() != c_depth);
        m_underrun = 1'b0;
        m_sclk     = ((cyc / c_div) % 2) == 1;
        if (cyc % (2 * c_div) == 0) begin
            n = cyc / (2 * c_div);
            k = (n - 1) % c_fw;
            if (k == c_load_k) begin
                if (m_q.size() != 0) begin
                    m_frame = m_q.pop_front();
                end else begin
                    m_frame    = '0;
                    m_underrun = 1'b1;
                end
            end
            idx     = (k - c_ofs + c_fw) % c_fw;
            m_sdata = m_frame[c_fw-1-idx];
            m_lrclk = (k >= c_w);
        end
        if (push_now) m_q.push_back({sample_left, sample_right});
    endtask

    task automatic check_outputs();
        check_eq("sclk",     32'(sclk),       32'(m_sclk));
        check_eq("lrclk",    32'(lrclk),      32'(m_lrclk));
        check_eq("sdata",    32'(sdata),      32'(m_sdata));
        check_eq("underrun", 32'(underrun),   32'(m_underrun));
        check_eq("level",    32'(fifo_level), 32'(m_q.size()));
        check_eq("ready",    32'(sample_ready), 32'(m_q.size() != c_depth));
    endtask

    // mode 0 idle, 1 always valid, 2 dense random, 3 sparse random
    task automatic drive(input int mode);
        case (mode)
            1:       sample_valid = 1'b1;
            2:       sample_valid = ($urandom_range(0, 3) == 0);
            3:       sample_valid = ($urandom_range(0, 199) == 0);
            default: sample_valid = 1'b0;
        endcase
        sample_left  = c_w'($urandom);
        sample_right = c_w'($urandom);
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
            drive(mode);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_sclk",     32'(sclk),         32'd0);
        check_eq("rst_lrclk",    32'(lrclk),        32'd0);
        check_eq("rst_sdata",    32'(sdata),        32'd0);
        check_eq("rst_underrun", 32'(underrun),     32'd0);
        check_eq("rst_level",    32'(fifo_level),   32'd0);
        check_eq("rst_ready",    32'(sample_ready), 32'd1);
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        #1;
        check_reset_values();
        repeat (3) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Directed frame: A5F0 / 0001, then idle so the next frame underruns.
        sample_valid = 1'b1;
        sample_left  = 16'hA5F0;
        sample_right = 16'h0001;
        run(1, 0);
        run(800, 0);

        // Back-to-back pushes fill the FIFO; held valid waits for a pop.
        drive(1);
        run(400, 1);
        run(300, 0);

        // Randomized traffic at two densities.
        run(600, 2);
        run(2000, 3);

        // Coincident push/pop at level 2, then reset mid-right-word with 3 queued.
        do_reset();
        drive(1);
        run(2, 1);
        run(1, 0);
        run(268, 0);
        drive(1);
        run(1, 0);
        drive(1);
        run(1, 0);
        run(159, 0);
        check_eq("mid_lrclk", 32'(lrclk),      32'd1);
        check_eq("mid_level", 32'(fifo_level), 32'd3);
        do_reset();
        run(300, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
